// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: sums the PE-mesh lane bus over N passes into D saturating
// accumulators and drains them one lane per handshake. Define PSUM_RELU_EN for ReLU on drain.
module psum_accumulator #(
    parameter int depth = 2,
    parameter int D     = (1 << depth),
    parameter int W     = 16,
    parameter int PW    = 8
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 start,
    input  logic [PW-1:0]        numPasses,
    input  logic [W*D-1:0]       psumIn,
    input  logic                 psumValid,
    output logic                 busy,
    output logic [W-1:0]         outData,
    output logic [depth-1:0]     outRow,
    output logic                 outValid,
    input  logic                 outReady,
    output logic                 done
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    localparam logic [depth-1:0] LAST_ROW = depth'(D - 1);
    localparam logic [W-1:0]     SAT_POS  = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]     SAT_NEG  = {1'b1, {(W-1){1'b0}}};

    state_t                  state, state_nxt;
    logic [D-1:0][W-1:0]     acc, acc_sum;
    logic [PW-1:0]           pass_cnt, passes;
    logic [depth-1:0]        row_idx;
    logic [W-1:0]            last_data, drain_data, acc_sel;
    logic                    last_beat, xfer, last_row;

    // One extra bit of headroom per lane; a sign mismatch between the top two bits is overflow.
    for (genvar i = 0; i < D; i++) begin : g_lane
        logic [W-1:0] lane;
        logic [W:0]   sum;
        assign lane = psumIn[W*(i+1)-1 -: W];
        assign sum  = {acc[i][W-1], acc[i]} + {lane[W-1], lane};
        assign acc_sum[i] = (sum[W] == sum[W-1]) ? sum[W-1:0] :
                            (sum[W] ? SAT_NEG : SAT_POS);
    end

    assign last_beat = psumValid && (pass_cnt == passes - 1'b1);
    assign xfer      = (state == DRAIN) && outReady;
    assign last_row  = (row_idx == LAST_ROW);
    assign acc_sel   = acc[row_idx];

`ifdef PSUM_RELU_EN
    assign drain_data = acc_sel[W-1] ? '0 : acc_sel;
`else
    assign drain_data = acc_sel;
`endif

    assign busy     = (state != IDLE);
    assign outValid = (state == DRAIN);
    assign outRow   = row_idx;
    // Outside DRAIN the bus keeps showing the last drained value.
    assign outData  = (state == DRAIN) ? drain_data : last_data;

    always_ff @(posedge CLK) begin
        if (!RSTn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (last_beat) state_nxt = DRAIN;
            DRAIN:   if (xfer && last_row) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            acc       <= '0;
            pass_cnt  <= '0;
            passes    <= '0;
            row_idx   <= '0;
            done      <= 1'b0;
            last_data <= '0;
        end else begin
            done <= xfer && last_row;
            case (state)
                IDLE: begin
                    if (start) begin
                        passes   <= (numPasses == '0) ? PW'(1) : numPasses;
                        acc      <= '0;
                        pass_cnt <= '0;
                    end
                end
                ACCUM: begin
                    if (psumValid) begin
                        acc      <= acc_sum;
                        pass_cnt <= pass_cnt + 1'b1;
                        if (last_beat) row_idx <= '0;
                    end
                end
                DRAIN: begin
                    last_data <= drain_data;
                    if (xfer) row_idx <= row_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Sits directly downstream of the convolutional unit's PE mesh; consumes the D-lane partial-sum bus it emits (one W-bit lane per mesh row).
- Accumulates that bus over a programmable number of passes (input channels / kernel tiles) into D signed saturating accumulators.
- Drains the D results one lane per handshake to the output/neuron-writeback memory.
- Optionally applies ReLU on drain.

Parameters:
depth, 2, log2 of mesh dimension
D, (1<<depth), lanes (mesh rows)
W, 16, signed data width per lane
PW, 8, width of pass-count register

Ports:
CLK  input  1  clock, all logic rising-edge
RSTn  input  1  synchronous active-low reset
start  input  1  begin new accumulation job (sampled only in IDLE)
numPasses  input  PW  passes to accumulate, latched on accepted start
psumIn  input  W*D  partial sums; lane i at [W*(i+1)-1 -: W], signed
psumValid  input  1  psumIn valid this cycle
busy  output  1  high whenever state != IDLE
outData  output  W  drained accumulator value
outRow  output  depth  lane index of outData
outValid  output  1  outData/outRow valid
outReady  input  1  downstream accepts
done  output  1  one-cycle pulse after last lane accepted

Behaviour:
- Reset (RSTn=0 at CLK edge): state=IDLE, all acc[i]=0, passCnt=0, rowIdx=0, passes=0; outputs busy=0, outValid=0, done=0, outData=0, outRow=0. Reset mid-job aborts with no done pulse.
- FSM states: IDLE, ACCUM, DRAIN.
- IDLE:
  - start=1: latch passes = (numPasses==0 ? 1 : numPasses); clear acc[] and passCnt; go to ACCUM next cycle.
  - psumValid ignored.
- ACCUM:
  - Each cycle with psumValid=1: acc[i] <= sat(acc[i] + lane i) for every i; passCnt++.
  - If passCnt == passes-1 on that beat: go to DRAIN, rowIdx=0.
  - psumValid=0: hold all state.
  - start ignored.
- DRAIN:
  - outValid=1; outData=acc[rowIdx] (post-ReLU if enabled); outRow=rowIdx.
  - Transfer = outValid & outReady. On transfer: rowIdx++. If rowIdx==D-1: go to IDLE and assert done for exactly the next cycle (done is registered, coincident with the IDLE cycle).
  - outData/outRow stable while outValid & !outReady.
  - psumValid and start ignored.
- Arithmetic: (W+1)-bit signed sum; clamp to +2^(W-1)-1 on positive overflow, -2^(W-1) on negative overflow.
- Latency:
  - Last psum beat to first outValid: 1 cycle.
  - Job minimum: 1 (start) + passes + D cycles with outReady tied high.
- Back-to-back: start asserted in the done cycle (state IDLE) is accepted.
- outValid=0 outside DRAIN; outData holds its last value.

Optional Feature:
- Macro PSUM_RELU_EN.
- Defined: outData = (acc[rowIdx] < 0) ? 0 : acc[rowIdx]. Accumulators themselves stay signed and unclamped below zero.
- Undefined: outData = acc[rowIdx] unmodified.

Test Plan:
- D=4, W=16, numPasses=3, lanes {1,2,3,4} on each of 3 consecutive valid beats, outReady=1 -> outData 3,6,9,12 with outRow 0..3 on consecutive cycles; done pulses once; busy spans start+1 through last drain.
- numPasses=2, psumValid gaps (valid, idle x3, valid) -> same sums as contiguous case; no early DRAIN.
- Lane0 = 0x7000 on two passes -> outData[row0]=0x7FFF (positive saturation). Lane1 = 0x9000 on two passes -> 0x8000 (negative saturation).
- DRAIN with outReady toggling 1,0,0,1,1,0,1 -> each lane delivered exactly once, values/rows held while stalled; done only after row 3 is accepted.
- numPasses=0 -> treated as 1 pass. RSTn=0 during DRAIN at rowIdx=2 -> next cycle IDLE, outValid=0, no done pulse. Fresh start afterwards works from zeroed accumulators.
- PSUM_RELU_EN defined, lane2 sums to -5 -> outData row2 = 0. Undefined -> 0xFFFB.
